// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcode/funct table,
// ALUOp and mux encodings, per-stage control bundles and their bubbles.
package ctrl_pkg;

    localparam int CTRL_REG_W   = 5;
    localparam int CTRL_ALUOP_W = 4;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_MUL   = 6'h1c;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Funct codes (R-type, plus mul under OP_MUL)
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_MUL  = 6'h02;

    // ALUOp codes
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 4'd0;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 4'd1;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNCT = 4'd2;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_MUL   = 4'd3;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_AND   = 4'd4;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SLT   = 4'd5;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_OR    = 4'd6;

    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b11
    } regdst_e;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC  = 2'b10
    } memtoreg_e;

    typedef struct packed {
        logic                  reg_write;
        memtoreg_e             mem_to_reg;
        logic [CTRL_REG_W-1:0] dst;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_read;
        logic     mem_write;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    typedef struct packed {
        logic                    alu_src1;
        logic                    alu_src2;
        logic                    ext_op;
        logic                    lu_op;
        logic [CTRL_ALUOP_W-1:0] alu_op;
        logic                    is_mul;
        logic [CTRL_REG_W-1:0]   rs;
        logic [CTRL_REG_W-1:0]   rt;
        mem_ctrl_t               mem;
    } ex_ctrl_t;

    localparam int WB_W  = $bits(wb_ctrl_t);
    localparam int MEM_W = $bits(mem_ctrl_t);
    localparam int EX_W  = $bits(ex_ctrl_t);

    localparam wb_ctrl_t WB_BUBBLE = '{
        reg_write:  1'b0,
        mem_to_reg: MTR_ALU,
        dst:        {CTRL_REG_W{1'b0}}
    };

    localparam mem_ctrl_t MEM_BUBBLE = '{
        mem_read:  1'b0,
        mem_write: 1'b0,
        wb:        WB_BUBBLE
    };

    localparam ex_ctrl_t EX_BUBBLE = '{
        alu_src1: 1'b0,
        alu_src2: 1'b0,
        ext_op:   1'b0,
        lu_op:    1'b0,
        alu_op:   ALUOP_FUNCT,
        is_mul:   1'b0,
        rs:       {CTRL_REG_W{1'b0}},
        rt:       {CTRL_REG_W{1'b0}},
        mem:      MEM_BUBBLE
    };

    // $0 is hard-wired, so it never counts as a producer/consumer match.
    function automatic logic reg_match(input logic [CTRL_REG_W-1:0] dst,
                                       input logic [CTRL_REG_W-1:0] src);
        return (dst != {CTRL_REG_W{1'b0}}) && (dst == src);
    endfunction

    // EX operand select: 10 from EX/MEM (non-load), else 01 from MEM/WB, else 00.
    function automatic logic [1:0] fwd_sel(input logic [CTRL_REG_W-1:0] src,
                                           input mem_ctrl_t             ex_mem,
                                           input wb_ctrl_t              mem_wb);
        logic [1:0] sel;
        if (ex_mem.wb.reg_write && !ex_mem.mem_read && reg_match(ex_mem.wb.dst, src)) begin
            sel = 2'b10;
        end else if (mem_wb.reg_write && reg_match(mem_wb.dst, src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: full ID/EX control bundle, source use-mask,
// control-flow class and illegal flag. Invalid or undecodable slots yield a bubble.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic                  id_valid_i,
    input  logic [5:0]            op_i,
    input  logic [5:0]            funct_i,
    input  logic [CTRL_REG_W-1:0] rs_i,
    input  logic [CTRL_REG_W-1:0] rt_i,
    input  logic [CTRL_REG_W-1:0] rd_i,
    output ex_ctrl_t              bundle_o,
    output logic                  use_rs_o,
    output logic                  use_rt_o,
    output logic                  is_branch_o,
    output logic                  is_jump_o,
    output logic                  is_jr_o,
    output logic                  illegal_o
);

    ex_ctrl_t raw_s;
    regdst_e  reg_dst_s;
    logic     use_rs_s;
    logic     use_rt_s;
    logic     branch_s;
    logic     jump_s;
    logic     jr_s;
    logic     legal_s;

    // Opcode/funct table lookup into raw control fields.
    always_comb begin
        raw_s     = EX_BUBBLE;
        reg_dst_s = REGDST_RT;
        use_rs_s  = 1'b0;
        use_rt_s  = 1'b0;
        branch_s  = 1'b0;
        jump_s    = 1'b0;
        jr_s      = 1'b0;
        legal_s   = 1'b1;
        case (op_i)
            OP_RTYPE: begin
                raw_s.alu_op = ALUOP_FUNCT;
                reg_dst_s    = REGDST_RD;
                case (funct_i)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SLT: begin
                        raw_s.mem.wb.reg_write = 1'b1;
                        use_rs_s = 1'b1;
                        use_rt_s = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        raw_s.alu_src1         = 1'b1;
                        raw_s.mem.wb.reg_write = 1'b1;
                        use_rt_s = 1'b1;
                    end
                    FN_JR: begin
                        jr_s     = 1'b1;
                        use_rs_s = 1'b1;
                    end
                    FN_JALR: begin
                        jr_s     = 1'b1;
                        use_rs_s = 1'b1;
                        raw_s.mem.wb.reg_write  = 1'b1;
                        raw_s.mem.wb.mem_to_reg = MTR_PC;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_MUL: begin
                if (funct_i == FN_MUL) begin
                    raw_s.alu_op           = ALUOP_MUL;
                    raw_s.is_mul           = 1'b1;
                    raw_s.mem.wb.reg_write = 1'b1;
                    reg_dst_s = REGDST_RD;
                    use_rs_s  = 1'b1;
                    use_rt_s  = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
                raw_s.alu_src2         = 1'b1;
                raw_s.mem.wb.reg_write = 1'b1;
                use_rs_s = 1'b1;
                case (op_i)
                    OP_ANDI: begin raw_s.alu_op = ALUOP_AND; raw_s.ext_op = 1'b0; end
                    OP_ORI:  begin raw_s.alu_op = ALUOP_OR;  raw_s.ext_op = 1'b0; end
                    OP_SLTI, OP_SLTIU: begin raw_s.alu_op = ALUOP_SLT; raw_s.ext_op = 1'b1; end
                    default: begin raw_s.alu_op = ALUOP_ADD; raw_s.ext_op = 1'b1; end
                endcase
            end
            OP_LUI: begin
                raw_s.alu_src2         = 1'b1;
                raw_s.lu_op            = 1'b1;
                raw_s.alu_op           = ALUOP_ADD;
                raw_s.mem.wb.reg_write = 1'b1;
            end
            OP_LW: begin
                raw_s.alu_src2          = 1'b1;
                raw_s.ext_op            = 1'b1;
                raw_s.alu_op            = ALUOP_ADD;
                raw_s.mem.mem_read      = 1'b1;
                raw_s.mem.wb.reg_write  = 1'b1;
                raw_s.mem.wb.mem_to_reg = MTR_MEM;
                use_rs_s = 1'b1;
            end
            OP_SW: begin
                raw_s.alu_src2      = 1'b1;
                raw_s.ext_op        = 1'b1;
                raw_s.alu_op        = ALUOP_ADD;
                raw_s.mem.mem_write = 1'b1;
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                raw_s.ext_op = 1'b1;
                raw_s.alu_op = ALUOP_SUB;
                branch_s = 1'b1;
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
            end
            OP_J: begin
                jump_s = 1'b1;
            end
            OP_JAL: begin
                jump_s    = 1'b1;
                reg_dst_s = REGDST_RA;
                raw_s.mem.wb.reg_write  = 1'b1;
                raw_s.mem.wb.mem_to_reg = MTR_PC;
            end
            default: legal_s = 1'b0;
        endcase

        // Destination resolved here; non-writers carry dst=0.
        if (raw_s.mem.wb.reg_write) begin
            case (reg_dst_s)
                REGDST_RT: raw_s.mem.wb.dst = rt_i;
                REGDST_RD: raw_s.mem.wb.dst = rd_i;
                REGDST_RA: raw_s.mem.wb.dst = {CTRL_REG_W{1'b1}};
                default:   raw_s.mem.wb.dst = {CTRL_REG_W{1'b0}};
            endcase
        end else begin
            raw_s.mem.wb.dst = {CTRL_REG_W{1'b0}};
        end
        // Unused source fields are zeroed so they never match a forward.
        raw_s.rs = use_rs_s ? rs_i : {CTRL_REG_W{1'b0}};
        raw_s.rt = use_rt_s ? rt_i : {CTRL_REG_W{1'b0}};
    end

    // Empty or undecodable slot becomes a bubble with no side effects.
    always_comb begin
        illegal_o = id_valid_i & ~legal_s;
        if (id_valid_i && legal_s) begin
            bundle_o    = raw_s;
            use_rs_o    = use_rs_s;
            use_rt_o    = use_rt_s;
            is_branch_o = branch_s;
            is_jump_o   = jump_s;
            is_jr_o     = jr_s;
        end else begin
            bundle_o    = EX_BUBBLE;
            use_rs_o    = 1'b0;
            use_rt_o    = 1'b0;
            is_branch_o = 1'b0;
            is_jump_o   = 1'b0;
            is_jr_o     = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use and branch-operand stalls, forwarding selects, flush and mul hold.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic [REG_W-1:0] Rs,
    input  logic [REG_W-1:0] Rt,
    input  logic [REG_W-1:0] Rd,
    input  logic             branch_taken,
    output logic [EX_W-1:0]  ex_bundle,
    output logic [MEM_W-1:0] mem_bundle,
    output logic [WB_W-1:0]  wb_bundle,
    output logic             pc_stall,
    output logic             flush_ifid,
    output logic             jump,
    output logic             jump_reg,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             illegal,
    output logic             ex_busy
);

    // Bundle layout is fixed by the package; reject mismatched overrides.
    if (REG_W != CTRL_REG_W || ALUOP_W != CTRL_ALUOP_W || MUL_LAT < 1) begin : g_param_check
        $error("pipe_ctrl_unit: REG_W/ALUOP_W must match ctrl_pkg and MUL_LAT >= 1");
    end

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    ex_ctrl_t         dec_bundle_s;
    logic             dec_use_rs_s;
    logic             dec_use_rt_s;
    logic             dec_branch_s;
    logic             dec_jump_s;
    logic             dec_jr_s;
    logic             dec_illegal_s;

    ex_ctrl_t         id_ex_q,   id_ex_d;
    mem_ctrl_t        ex_mem_q,  ex_mem_d;
    wb_ctrl_t         mem_wb_q,  mem_wb_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    logic             busy_s;
    logic             load_use_s;
    logic             br_stall_s;
    logic             stall_s;

    ctrl_decode u_decode (
        .id_valid_i  (id_valid),
        .op_i        (OpCode),
        .funct_i     (Funct),
        .rs_i        (Rs),
        .rt_i        (Rt),
        .rd_i        (Rd),
        .bundle_o    (dec_bundle_s),
        .use_rs_o    (dec_use_rs_s),
        .use_rt_o    (dec_use_rt_s),
        .is_branch_o (dec_branch_s),
        .is_jump_o   (dec_jump_s),
        .is_jr_o     (dec_jr_s),
        .illegal_o   (dec_illegal_s)
    );

    // Hazard detection, front-end control and next-state of the stage registers.
    always_comb begin
        busy_s = (mul_cnt_q != {CNT_W{1'b0}});

        load_use_s = id_ex_q.mem.mem_read &&
                     ((dec_use_rs_s && reg_match(id_ex_q.mem.wb.dst, Rs)) ||
                      (dec_use_rt_s && reg_match(id_ex_q.mem.wb.dst, Rt)));

        // Branch/jr compare in ID: needs results not yet forwardable to ID.
        br_stall_s = (dec_branch_s || dec_jr_s) &&
                     ((id_ex_q.mem.wb.reg_write &&
                       ((dec_use_rs_s && reg_match(id_ex_q.mem.wb.dst, Rs)) ||
                        (dec_use_rt_s && reg_match(id_ex_q.mem.wb.dst, Rt)))) ||
                      (ex_mem_q.mem_read &&
                       ((dec_use_rs_s && reg_match(ex_mem_q.wb.dst, Rs)) ||
                        (dec_use_rt_s && reg_match(ex_mem_q.wb.dst, Rt)))));

        stall_s = load_use_s || br_stall_s;

        pc_stall   = busy_s || stall_s;
        flush_ifid = !busy_s && !stall_s &&
                     (dec_jump_s || dec_jr_s || (dec_branch_s && branch_taken));
        jump       = dec_jump_s;
        jump_reg   = dec_jr_s;
        illegal    = dec_illegal_s;
        ex_busy    = busy_s;

        mem_wb_d = ex_mem_q.wb;
        if (busy_s) begin
            // mul still computing: hold it in EX, drain bubbles behind it.
            id_ex_d   = id_ex_q;
            ex_mem_d  = MEM_BUBBLE;
            mul_cnt_d = mul_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            id_ex_d   = stall_s ? EX_BUBBLE : dec_bundle_s;
            ex_mem_d  = id_ex_q.mem;
            mul_cnt_d = (!stall_s && dec_bundle_s.is_mul) ? CNT_LOAD : {CNT_W{1'b0}};
        end
    end

    // Stage registers and mul counter with synchronous reset to bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q   <= EX_BUBBLE;
            ex_mem_q  <= MEM_BUBBLE;
            mem_wb_q  <= WB_BUBBLE;
            mul_cnt_q <= {CNT_W{1'b0}};
        end else begin
            id_ex_q   <= id_ex_d;
            ex_mem_q  <= ex_mem_d;
            mem_wb_q  <= mem_wb_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Forwarding selects for the instruction currently in EX.
    always_comb begin
        fwd_a = fwd_sel(id_ex_q.rs, ex_mem_q, mem_wb_q);
        fwd_b = fwd_sel(id_ex_q.rt, ex_mem_q, mem_wb_q);
    end

    assign ex_bundle  = id_ex_q;
    assign mem_bundle = ex_mem_q;
    assign wb_bundle  = mem_wb_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit (MUL_LAT=4): reset, load-use, forwarding,
// branch flush/stall, mul hold with jal, reset mid-mul and illegal opcode.
module tb_pipe_ctrl_unit;
    import ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic [4:0]       Rs, Rt, Rd;
    logic             branch_taken;
    logic [EX_W-1:0]  ex_bundle;
    logic [MEM_W-1:0] mem_bundle;
    logic [WB_W-1:0]  wb_bundle;
    logic             pc_stall, flush_ifid, jump, jump_reg, illegal, ex_busy;
    logic [1:0]       fwd_a, fwd_b;

    ex_ctrl_t  ex_s;
    mem_ctrl_t mem_s;
    wb_ctrl_t  wb_s;
    assign ex_s  = ex_bundle;
    assign mem_s = mem_bundle;
    assign wb_s  = wb_bundle;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.MUL_LAT(4), .REG_W(5), .ALUOP_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .OpCode       (OpCode),
        .Funct        (Funct),
        .Rs           (Rs),
        .Rt           (Rt),
        .Rd           (Rd),
        .branch_taken (branch_taken),
        .ex_bundle    (ex_bundle),
        .mem_bundle   (mem_bundle),
        .wb_bundle    (wb_bundle),
        .pc_stall     (pc_stall),
        .flush_ifid   (flush_ifid),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .illegal      (illegal),
        .ex_busy      (ex_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic tk);
        id_valid     = v;
        OpCode       = op;
        Funct        = fn;
        Rs           = s;
        Rt           = t;
        Rd           = d;
        branch_taken = tk;
    endtask

    task automatic nop();
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex_bubble(input string tag);
        chk({tag, "_ex_rw"},  ex_s.mem.wb.reg_write, 1'b0);
        chk({tag, "_ex_mr"},  ex_s.mem.mem_read, 1'b0);
        chk({tag, "_ex_mw"},  ex_s.mem.mem_write, 1'b0);
        chk({tag, "_ex_mul"}, ex_s.is_mul, 1'b0);
        chk({tag, "_ex_dst"}, ex_s.mem.wb.dst, 5'd0);
        chk({tag, "_ex_aop"}, ex_s.alu_op, 4'd2);
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        settle();
        chk_ex_bubble("rst");
        chk("rst_mem_rw", mem_s.wb.reg_write, 1'b0);
        chk("rst_mem_mr", mem_s.mem_read, 1'b0);
        chk("rst_mem_dst", mem_s.wb.dst, 5'd0);
        chk("rst_wb_rw", wb_s.reg_write, 1'b0);
        chk("rst_wb_dst", wb_s.dst, 5'd0);
        chk("rst_stall", pc_stall, 1'b0);
        chk("rst_flush", flush_ifid, 1'b0);
        chk("rst_busy", ex_busy, 1'b0);
        chk("rst_fwd_a", fwd_a, 2'b00);
        chk("rst_fwd_b", fwd_b, 2'b00);
        chk("rst_illegal", illegal, 1'b0);
        tick();

        // lw $8, 0($9)
        drive(1'b1, 6'h23, 6'h00, 5'd9, 5'd8, 5'd0, 1'b0);
        settle();
        chk("lw_stall", pc_stall, 1'b0);
        tick();
        // add $9,$8,$10 right behind the load
        drive(1'b1, 6'h00, 6'h20, 5'd8, 5'd10, 5'd9, 1'b0);
        settle();
        chk("lu_ex_mr", ex_s.mem.mem_read, 1'b1);
        chk("lu_ex_dst", ex_s.mem.wb.dst, 5'd8);
        chk("lu_stall", pc_stall, 1'b1);
        chk("lu_flush", flush_ifid, 1'b0);
        tick();
        settle();
        chk("lu_stall_once", pc_stall, 1'b0);
        chk("lu_bub_rw", ex_s.mem.wb.reg_write, 1'b0);
        chk("lu_bub_dst", ex_s.mem.wb.dst, 5'd0);
        chk("lu_mem_mr", mem_s.mem_read, 1'b1);
        chk("lu_mem_dst", mem_s.wb.dst, 5'd8);
        tick();
        nop();
        settle();
        chk("lu_add_dst", ex_s.mem.wb.dst, 5'd9);
        chk("lu_add_rw", ex_s.mem.wb.reg_write, 1'b1);
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);
        chk("lu_wb_dst", wb_s.dst, 5'd8);
        chk("lu_wb_m2r", wb_s.mem_to_reg, 2'b01);
        tick();

        // add $8,$1,$2 ; sub $11,$8,$8 -> EX/MEM forward on both
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd8, 1'b0);
        settle();
        tick();
        drive(1'b1, 6'h00, 6'h22, 5'd8, 5'd8, 5'd11, 1'b0);
        settle();
        chk("fw_stall", pc_stall, 1'b0);
        tick();
        nop();
        settle();
        chk("fw_ex_dst", ex_s.mem.wb.dst, 5'd11);
        chk("fw_a_10", fwd_a, 2'b10);
        chk("fw_b_10", fwd_b, 2'b10);
        tick();

        // add $0,$1,$2 ; sub $11,$0,$0 -> no forward from $0
        drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 1'b0);
        settle();
        tick();
        drive(1'b1, 6'h00, 6'h22, 5'd0, 5'd0, 5'd11, 1'b0);
        settle();
        tick();
        nop();
        settle();
        chk("fw0_a", fwd_a, 2'b00);
        chk("fw0_b", fwd_b, 2'b00);
        tick();

        // beq $1,$2 taken, no hazard -> flush
        drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        settle();
        chk("beq_flush", flush_ifid, 1'b1);
        chk("beq_stall", pc_stall, 1'b0);
        tick();
        nop();
        settle();
        chk("beq_flush_once", flush_ifid, 1'b0);
        chk("beq_ex_aop", ex_s.alu_op, 4'd1);
        chk("beq_ex_rw", ex_s.mem.wb.reg_write, 1'b0);
        tick();

        // addi $5,$0,7 ; beq $5,$6 taken -> one stall, then flush
        drive(1'b1, 6'h08, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
        settle();
        tick();
        drive(1'b1, 6'h04, 6'h00, 5'd5, 5'd6, 5'd0, 1'b1);
        settle();
        chk("bh_stall", pc_stall, 1'b1);
        chk("bh_noflush", flush_ifid, 1'b0);
        tick();
        settle();
        chk("bh_stall_clr", pc_stall, 1'b0);
        chk("bh_flush", flush_ifid, 1'b1);
        tick();
        nop();
        settle();
        tick();

        // mul $12,$1,$2 followed by jal held during busy
        drive(1'b1, 6'h1c, 6'h02, 5'd1, 5'd2, 5'd12, 1'b0);
        settle();
        chk("mul_busy0", ex_busy, 1'b0);
        chk("mul_stall0", pc_stall, 1'b0);
        tick();
        drive(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        chk("mul_busy1", ex_busy, 1'b1);
        chk("mul_stall1", pc_stall, 1'b1);
        chk("mul_flush1", flush_ifid, 1'b0);
        chk("mul_jump", jump, 1'b1);
        chk("mul_ex_mul", ex_s.is_mul, 1'b1);
        chk("mul_ex_dst", ex_s.mem.wb.dst, 5'd12);
        tick();
        settle();
        chk("mul_busy2", ex_busy, 1'b1);
        chk("mul_flush2", flush_ifid, 1'b0);
        chk("mul_bub_rw", mem_s.wb.reg_write, 1'b0);
        chk("mul_bub_dst", mem_s.wb.dst, 5'd0);
        tick();
        settle();
        chk("mul_busy3", ex_busy, 1'b1);
        chk("mul_stall3", pc_stall, 1'b1);
        chk("mul_flush3", flush_ifid, 1'b0);
        tick();
        settle();
        chk("mul_busy_end", ex_busy, 1'b0);
        chk("mul_stall_end", pc_stall, 1'b0);
        chk("jal_flush", flush_ifid, 1'b1);
        chk("mul_ex_still", ex_s.is_mul, 1'b1);
        chk("mul_mem_bub", mem_s.wb.reg_write, 1'b0);
        tick();
        nop();
        settle();
        chk("mul_mem_rw", mem_s.wb.reg_write, 1'b1);
        chk("mul_mem_dst", mem_s.wb.dst, 5'd12);
        chk("jal_ex_dst", ex_s.mem.wb.dst, 5'd31);
        chk("jal_ex_m2r", ex_s.mem.wb.mem_to_reg, 2'b10);
        chk("jal_flush_once", flush_ifid, 1'b0);
        tick();

        // mul $13,$3,$4 with reset in the second busy cycle
        drive(1'b1, 6'h1c, 6'h02, 5'd3, 5'd4, 5'd13, 1'b0);
        settle();
        tick();
        nop();
        settle();
        chk("rm_busy1", ex_busy, 1'b1);
        tick();
        reset = 1'b1;
        settle();
        chk("rm_busy2", ex_busy, 1'b1);
        tick();
        reset = 1'b0;
        settle();
        chk("rm_busy", ex_busy, 1'b0);
        chk("rm_stall", pc_stall, 1'b0);
        chk_ex_bubble("rm");
        chk("rm_mem_rw", mem_s.wb.reg_write, 1'b0);
        chk("rm_mem_dst", mem_s.wb.dst, 5'd0);
        chk("rm_wb_rw", wb_s.reg_write, 1'b0);
        chk("rm_wb_dst", wb_s.dst, 5'd0);
        tick();

        // Unknown opcode 6'h3f
        drive(1'b1, 6'h3f, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        settle();
        chk("ill_flag", illegal, 1'b1);
        chk("ill_stall", pc_stall, 1'b0);
        chk("ill_flush", flush_ifid, 1'b0);
        chk("ill_jump", jump, 1'b0);
        tick();
        nop();
        settle();
        chk_ex_bubble("ill");
        chk("ill_clear", illegal, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
